// File: rtl/hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and hazard_ctrl.
//   ID-stage request : valid_D, rs1_D, rs2_D, use1_D, use2_D, rd_D,
//                      regWrite_D, memRead_D, branch_taken
//   Control response : stall_F, stall_D, flush_D, flush_E, flush_M,
//                      fwdA_E, fwdB_E, fwd1_D, fwd2_D
//   Counters         : stall_cnt, flush_cnt
// master = datapath side, slave = hazard_ctrl side.
interface hazard_ctrl_if #(
  parameter int RAW   = 5,
  parameter int CNT_W = 16
);
  logic           valid_D;
  logic [RAW-1:0] rs1_D;
  logic [RAW-1:0] rs2_D;
  logic           use1_D;
  logic           use2_D;
  logic [RAW-1:0] rd_D;
  logic           regWrite_D;
  logic           memRead_D;
  logic           branch_taken;

  logic           stall_F;
  logic           stall_D;
  logic           flush_D;
  logic           flush_E;
  logic           flush_M;
  logic [1:0]     fwdA_E;
  logic [1:0]     fwdB_E;
  logic           fwd1_D;
  logic           fwd2_D;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output valid_D, rs1_D, rs2_D, use1_D, use2_D, rd_D, regWrite_D,
           memRead_D, branch_taken,
    input  stall_F, stall_D, flush_D, flush_E, flush_M, fwdA_E, fwdB_E,
           fwd1_D, fwd2_D, stall_cnt, flush_cnt
  );

  modport slave (
    input  valid_D, rs1_D, rs2_D, use1_D, use2_D, rd_D, regWrite_D,
           memRead_D, branch_taken,
    output stall_F, stall_D, flush_D, flush_E, flush_M, fwdA_E, fwdB_E,
           fwd1_D, fwd2_D, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control for the 5-stage LEGv8 core.
// Tracks a shadow pipeline of register tags for EX, MEM and WB and derives
// forwarding selects, load-use / RAW stalls and taken-branch flushes, plus
// saturating stall and flush event counters.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; all tags invalid, counters cleared
//   hz    : hazard_ctrl_if.slave (ID-stage request in, control out)
module hazard_ctrl #(
  parameter int RAW      = 5,
  parameter int ZERO_REG = 31,
  parameter int BR_STAGE = 3,
  parameter int FWD_EN   = 1,
  parameter int CNT_W    = 16
) (
  input logic          clk,
  input logic          reset,
  hazard_ctrl_if.slave hz
);

  localparam logic [RAW-1:0] ZR = RAW'(ZERO_REG);

  typedef struct packed {
    logic           valid;
    logic           regWrite;
    logic           memRead;
    logic           use1;
    logic           use2;
    logic [RAW-1:0] rd;
    logic [RAW-1:0] rs1;
    logic [RAW-1:0] rs2;
  } ex_tag_t;

  // MEM and WB only ever act as writers, so they carry the writer fields.
  typedef struct packed {
    logic           valid;
    logic           regWrite;
    logic [RAW-1:0] rd;
  } wr_tag_t;

  ex_tag_t tag_e;
  wr_tag_t tag_m;
  wr_tag_t tag_w;

  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  logic       e_src1, e_src2;
  logic       d1_e, d2_e, d1_m, d2_m;
  logic       load_use, raw_stall, stall_req;
  logic [1:0] fwd_a, fwd_b;
  logic       stall, flush_e, flush_m;

  function automatic logic writes(input logic v, input logic rw,
                                  input logic [RAW-1:0] rd,
                                  input logic [RAW-1:0] r);
    return v & rw & (rd == r) & (r != ZR);
  endfunction

  always_comb begin
    e_src1 = tag_e.valid & tag_e.use1;
    e_src2 = tag_e.valid & tag_e.use2;

    d1_e = hz.valid_D & hz.use1_D & writes(tag_e.valid, tag_e.regWrite, tag_e.rd, hz.rs1_D);
    d2_e = hz.valid_D & hz.use2_D & writes(tag_e.valid, tag_e.regWrite, tag_e.rd, hz.rs2_D);
    d1_m = hz.valid_D & hz.use1_D & writes(tag_m.valid, tag_m.regWrite, tag_m.rd, hz.rs1_D);
    d2_m = hz.valid_D & hz.use2_D & writes(tag_m.valid, tag_m.regWrite, tag_m.rd, hz.rs2_D);

    load_use  = tag_e.memRead & (d1_e | d2_e);
    // Without EX forwarding any producer still in EX or MEM blocks the reader;
    // a producer in WB is handled by the WB->ID bypass.
    raw_stall = d1_e | d2_e | d1_m | d2_m;
    stall_req = (FWD_EN != 0) ? load_use : raw_stall;

    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (FWD_EN != 0) begin
      if (e_src1 & writes(tag_m.valid, tag_m.regWrite, tag_m.rd, tag_e.rs1))
        fwd_a = 2'b10;
      else if (e_src1 & writes(tag_w.valid, tag_w.regWrite, tag_w.rd, tag_e.rs1))
        fwd_a = 2'b01;
      if (e_src2 & writes(tag_m.valid, tag_m.regWrite, tag_m.rd, tag_e.rs2))
        fwd_b = 2'b10;
      else if (e_src2 & writes(tag_w.valid, tag_w.regWrite, tag_w.rd, tag_e.rs2))
        fwd_b = 2'b01;
    end
  end

  // A taken branch overrides any stall so the PC loads the branch target.
  assign stall   = stall_req & ~hz.branch_taken;
  assign flush_e = stall_req | hz.branch_taken;
  assign flush_m = (BR_STAGE == 3) & hz.branch_taken;

  assign hz.stall_F   = stall;
  assign hz.stall_D   = stall;
  assign hz.flush_D   = hz.branch_taken;
  assign hz.flush_E   = flush_e;
  assign hz.flush_M   = flush_m;
  assign hz.fwdA_E    = fwd_a;
  assign hz.fwdB_E    = fwd_b;
  assign hz.fwd1_D    = hz.use1_D & writes(tag_w.valid, tag_w.regWrite, tag_w.rd, hz.rs1_D);
  assign hz.fwd2_D    = hz.use2_D & writes(tag_w.valid, tag_w.regWrite, tag_w.rd, hz.rs2_D);
  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_e       <= '0;
      tag_m       <= '0;
      tag_w       <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      tag_w <= tag_m;

      if (flush_m) begin
        tag_m <= '0;
      end else begin
        tag_m.valid    <= tag_e.valid;
        tag_m.regWrite <= tag_e.regWrite;
        tag_m.rd       <= tag_e.rd;
      end

      if (flush_e) begin
        tag_e <= '0;
      end else begin
        tag_e.valid    <= hz.valid_D;
        tag_e.regWrite <= hz.regWrite_D;
        tag_e.memRead  <= hz.memRead_D;
        tag_e.use1     <= hz.use1_D;
        tag_e.use2     <= hz.use2_D;
        tag_e.rd       <= hz.rd_D;
        tag_e.rs1      <= hz.rs1_D;
        tag_e.rs2      <= hz.rs2_D;
      end

      if (stall && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 1'b1;
      if (hz.branch_taken && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // dut_a: forwarding on, branch resolved in MEM, 4-bit counters.
  // dut_b: forwarding off, branch resolved in EX, 16-bit counters.
  hazard_ctrl_if #(.RAW(5), .CNT_W(4))  ifa ();
  hazard_ctrl_if #(.RAW(5), .CNT_W(16)) ifb ();

  hazard_ctrl #(.RAW(5), .ZERO_REG(31), .BR_STAGE(3), .FWD_EN(1), .CNT_W(4)) dut_a (
    .clk(clk), .reset(reset), .hz(ifa)
  );
  hazard_ctrl #(.RAW(5), .ZERO_REG(31), .BR_STAGE(2), .FWD_EN(0), .CNT_W(16)) dut_b (
    .clk(clk), .reset(reset), .hz(ifb)
  );

  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic       br;
  } id_t;

  // Control vector: {stall_F, stall_D, flush_D, flush_E, flush_M, fwdA_E, fwdB_E, fwd1_D, fwd2_D}
  typedef struct {
    id_t         id;
    bit          ca;
    logic [10:0] ea;
    bit          cb;
    logic [10:0] eb;
    logic [10:0] mb;
  } row_t;

  row_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  function automatic id_t ins(bit v, int rs1, int rs2, bit u1, bit u2, int rd, bit rw, bit mr, bit br);
    id_t x;
    x.v = v; x.rs1 = rs1[4:0]; x.rs2 = rs2[4:0]; x.u1 = u1; x.u2 = u2;
    x.rd = rd[4:0]; x.rw = rw; x.mr = mr; x.br = br;
    return x;
  endfunction

  function automatic id_t alu(int rd, int rs1, int rs2);
    return ins(1, rs1, rs2, 1, 1, rd, 1, 0, 0);
  endfunction

  function automatic id_t ldur(int rd, int rs1);
    return ins(1, rs1, 0, 1, 0, rd, 1, 1, 0);
  endfunction

  function automatic id_t nop();
    return ins(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic row_t ra(id_t id, logic [10:0] ea);
    row_t r;
    r.id = id; r.ca = 1'b1; r.ea = ea; r.cb = 1'b0; r.eb = '0; r.mb = '0;
    return r;
  endfunction

  function automatic row_t rab(id_t id, bit ca, logic [10:0] ea, logic [10:0] eb, logic [10:0] mb);
    row_t r;
    r.id = id; r.ca = ca; r.ea = ea; r.cb = 1'b1; r.eb = eb; r.mb = mb;
    return r;
  endfunction

  function automatic logic [10:0] obs_a();
    return {ifa.stall_F, ifa.stall_D, ifa.flush_D, ifa.flush_E, ifa.flush_M,
            ifa.fwdA_E, ifa.fwdB_E, ifa.fwd1_D, ifa.fwd2_D};
  endfunction

  function automatic logic [10:0] obs_b();
    return {ifb.stall_F, ifb.stall_D, ifb.flush_D, ifb.flush_E, ifb.flush_M,
            ifb.fwdA_E, ifb.fwdB_E, ifb.fwd1_D, ifb.fwd2_D};
  endfunction

  task automatic drive(input id_t x);
    ifa.valid_D = x.v; ifa.rs1_D = x.rs1; ifa.rs2_D = x.rs2; ifa.use1_D = x.u1;
    ifa.use2_D = x.u2; ifa.rd_D = x.rd; ifa.regWrite_D = x.rw; ifa.memRead_D = x.mr;
    ifa.branch_taken = x.br;
    ifb.valid_D = x.v; ifb.rs1_D = x.rs1; ifb.rs2_D = x.rs2; ifb.use1_D = x.u1;
    ifb.use2_D = x.u2; ifb.rd_D = x.rd; ifb.regWrite_D = x.rw; ifb.memRead_D = x.mr;
    ifb.branch_taken = x.br;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    drive(nop());
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(nop());
    @(posedge clk); #1;
    vectors++; if (obs_a() !== 11'b0) begin miscompares++; $display("FAIL reset_ctl_a: got %b expected %b", obs_a(), 11'b0); end
    vectors++; if (obs_b() !== 11'b0) begin miscompares++; $display("FAIL reset_ctl_b: got %b expected %b", obs_b(), 11'b0); end
    vectors++; if (ifa.stall_cnt !== 4'd0) begin miscompares++; $display("FAIL reset_stall_cnt_a: got %0d expected 0", ifa.stall_cnt); end
    vectors++; if (ifa.flush_cnt !== 4'd0) begin miscompares++; $display("FAIL reset_flush_cnt_a: got %0d expected 0", ifa.flush_cnt); end
    vectors++; if (ifb.stall_cnt !== 16'd0) begin miscompares++; $display("FAIL reset_stall_cnt_b: got %0d expected 0", ifb.stall_cnt); end
    reset = 1'b0;
  endtask

  task automatic test_fwd_alu();
    row_t rows[$];
    row_t e;
    do_reset();
    rows.push_back(ra(alu(1, 2, 3),  11'b00000_00_00_00));
    rows.push_back(ra(alu(4, 1, 5),  11'b00000_00_00_00));
    rows.push_back(ra(alu(1, 6, 7),  11'b00000_10_00_00));
    rows.push_back(ra(alu(8, 5, 1),  11'b00000_00_00_01));
    rows.push_back(ra(nop(),         11'b00000_00_10_00));
    rows.push_back(ra(nop(),         11'b00000_00_00_00));
    rows.push_back(ra(alu(9, 2, 3),  11'b00000_00_00_00));
    rows.push_back(ra(alu(9, 2, 3),  11'b00000_00_00_00));
    rows.push_back(ra(alu(10, 9, 9), 11'b00000_00_00_00));
    rows.push_back(ra(nop(),         11'b00000_10_10_00));
    foreach (rows[i]) begin
      @(posedge clk); #1; drive(rows[i].id); sb.push_back(rows[i]);
      @(negedge clk); e = sb.pop_front();
      vectors++;
      if (obs_a() !== e.ea) begin miscompares++; $display("FAIL fwd_alu[%0d]: dutA ctl %b expected %b", i, obs_a(), e.ea); end
    end
    vectors++; if (ifa.stall_cnt !== 4'd0) begin miscompares++; $display("FAIL fwd_alu_stall_cnt: got %0d expected 0", ifa.stall_cnt); end
  endtask

  task automatic test_load_use();
    row_t rows[$];
    row_t e;
    do_reset();
    rows.push_back(ra(ldur(1, 2),   11'b00000_00_00_00));
    rows.push_back(ra(alu(3, 1, 1), 11'b11010_00_00_00));
    rows.push_back(ra(alu(3, 1, 1), 11'b00000_00_00_00));
    rows.push_back(ra(nop(),        11'b00000_01_01_00));
    foreach (rows[i]) begin
      @(posedge clk); #1; drive(rows[i].id); sb.push_back(rows[i]);
      @(negedge clk); e = sb.pop_front();
      vectors++;
      if (obs_a() !== e.ea) begin miscompares++; $display("FAIL load_use[%0d]: dutA ctl %b expected %b", i, obs_a(), e.ea); end
    end
    vectors++; if (ifa.stall_cnt !== 4'd1) begin miscompares++; $display("FAIL load_use_stall_cnt: got %0d expected 1", ifa.stall_cnt); end
  endtask

  task automatic test_zero_reg();
    row_t rows[$];
    row_t e;
    do_reset();
    rows.push_back(ra(alu(31, 2, 3),  11'b0));
    rows.push_back(ra(alu(4, 31, 31), 11'b0));
    rows.push_back(ra(ldur(31, 2),    11'b0));
    rows.push_back(ra(alu(5, 31, 31), 11'b0));
    rows.push_back(ra(nop(),          11'b0));
    rows.push_back(ra(nop(),          11'b0));
    foreach (rows[i]) begin
      @(posedge clk); #1; drive(rows[i].id); sb.push_back(rows[i]);
      @(negedge clk); e = sb.pop_front();
      vectors++;
      if (obs_a() !== e.ea) begin miscompares++; $display("FAIL zero_reg[%0d]: dutA ctl %b expected %b", i, obs_a(), e.ea); end
    end
    vectors++; if (ifa.stall_cnt !== 4'd0) begin miscompares++; $display("FAIL zero_reg_stall_cnt: got %0d expected 0", ifa.stall_cnt); end
  endtask

  task automatic test_wb_bypass();
    row_t rows[$];
    row_t e;
    do_reset();
    rows.push_back(ra(alu(7, 2, 3), 11'b0));
    rows.push_back(ra(alu(8, 2, 3), 11'b0));
    rows.push_back(ra(alu(9, 2, 3), 11'b0));
    rows.push_back(ra(ins(1, 7, 7, 1, 0, 10, 1, 0, 0), 11'b00000_00_00_10));
    rows.push_back(ra(nop(),        11'b0));
    foreach (rows[i]) begin
      @(posedge clk); #1; drive(rows[i].id); sb.push_back(rows[i]);
      @(negedge clk); e = sb.pop_front();
      vectors++;
      if (obs_a() !== e.ea) begin miscompares++; $display("FAIL wb_bypass[%0d]: dutA ctl %b expected %b", i, obs_a(), e.ea); end
    end
  endtask

  task automatic test_branch_flush();
    row_t rows[$];
    row_t e;
    id_t  br;
    do_reset();
    br = alu(3, 1, 1);
    br.br = 1'b1;
    rows.push_back(rab(ldur(1, 2),   1, 11'b00000_00_00_00, 11'b00000_00_00_00, '1));
    rows.push_back(rab(br,           1, 11'b00111_00_00_00, 11'b00110_00_00_00, '1));
    rows.push_back(rab(alu(3, 1, 1), 1, 11'b00000_00_00_00, 11'b11010_00_00_00, '1));
    rows.push_back(rab(nop(),        1, 11'b00000_00_00_00, 11'b00000_00_00_00, '1));
    foreach (rows[i]) begin
      @(posedge clk); #1; drive(rows[i].id); sb.push_back(rows[i]);
      @(negedge clk); e = sb.pop_front();
      vectors++;
      if (obs_a() !== e.ea) begin miscompares++; $display("FAIL branch_flush[%0d]: dutA ctl %b expected %b", i, obs_a(), e.ea); end
      vectors++;
      if ((obs_b() & e.mb) !== (e.eb & e.mb)) begin miscompares++; $display("FAIL branch_flush[%0d]: dutB ctl %b expected %b", i, obs_b(), e.eb); end
    end
    vectors++; if (ifa.flush_cnt !== 4'd1) begin miscompares++; $display("FAIL branch_flush_cnt_a: got %0d expected 1", ifa.flush_cnt); end
    vectors++; if (ifa.stall_cnt !== 4'd0) begin miscompares++; $display("FAIL branch_stall_cnt_a: got %0d expected 0", ifa.stall_cnt); end
    vectors++; if (ifb.flush_cnt !== 16'd1) begin miscompares++; $display("FAIL branch_flush_cnt_b: got %0d expected 1", ifb.flush_cnt); end
    vectors++; if (ifb.stall_cnt !== 16'd1) begin miscompares++; $display("FAIL branch_stall_cnt_b: got %0d expected 1", ifb.stall_cnt); end
  endtask

  task automatic test_no_forward();
    row_t rows[$];
    row_t e;
    do_reset();
    rows.push_back(rab(alu(1, 2, 3), 0, '0, 11'b00000_00_00_00, '1));
    rows.push_back(rab(alu(4, 1, 5), 0, '0, 11'b11010_00_00_00, '1));
    rows.push_back(rab(alu(4, 1, 5), 0, '0, 11'b11010_00_00_00, '1));
    rows.push_back(rab(alu(4, 1, 5), 0, '0, 11'b00000_00_00_00, 11'b11111_11_11_00));
    rows.push_back(rab(nop(),        0, '0, 11'b00000_00_00_00, '1));
    foreach (rows[i]) begin
      @(posedge clk); #1; drive(rows[i].id); sb.push_back(rows[i]);
      @(negedge clk); e = sb.pop_front();
      vectors++;
      if ((obs_b() & e.mb) !== (e.eb & e.mb)) begin miscompares++; $display("FAIL no_forward[%0d]: dutB ctl %b expected %b", i, obs_b(), e.eb); end
    end
    vectors++; if (ifb.stall_cnt !== 16'd2) begin miscompares++; $display("FAIL no_forward_stall_cnt: got %0d expected 2", ifb.stall_cnt); end
  endtask

  task automatic test_reset_mid_stall();
    row_t rows[$];
    row_t e;
    do_reset();
    rows.push_back(ra(ldur(1, 2),   11'b00000_00_00_00));
    rows.push_back(ra(alu(3, 1, 1), 11'b11010_00_00_00));
    rows.push_back(ra(alu(3, 1, 1), 11'b00000_00_00_00));
    rows.push_back(ra(ldur(1, 2),   11'b00000_01_01_00));
    rows.push_back(ra(alu(3, 1, 1), 11'b11010_00_00_00));
    foreach (rows[i]) begin
      @(posedge clk); #1; drive(rows[i].id); sb.push_back(rows[i]);
      @(negedge clk); e = sb.pop_front();
      vectors++;
      if (obs_a() !== e.ea) begin miscompares++; $display("FAIL reset_mid[%0d]: dutA ctl %b expected %b", i, obs_a(), e.ea); end
    end
    vectors++; if (ifa.stall_cnt !== 4'd1) begin miscompares++; $display("FAIL reset_mid_pre_cnt: got %0d expected 1", ifa.stall_cnt); end
    reset = 1'b1;
    #1;
    vectors++; if (obs_a() !== 11'b0) begin miscompares++; $display("FAIL reset_mid_async_ctl: got %b expected %b", obs_a(), 11'b0); end
    vectors++; if (ifa.stall_cnt !== 4'd0) begin miscompares++; $display("FAIL reset_mid_async_cnt: got %0d expected 0", ifa.stall_cnt); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    vectors++; if (obs_a() !== 11'b0) begin miscompares++; $display("FAIL reset_mid_after_ctl: got %b expected %b", obs_a(), 11'b0); end
    vectors++; if (ifa.stall_cnt !== 4'd0) begin miscompares++; $display("FAIL reset_mid_after_cnt: got %0d expected 0", ifa.stall_cnt); end
  endtask

  task automatic test_saturation();
    id_t br;
    do_reset();
    for (int p = 0; p < 21; p++) begin
      @(posedge clk); #1; drive(ldur(1, 2));
      @(posedge clk); #1; drive(alu(3, 1, 1));
      @(negedge clk);
      if (p == 14) begin
        vectors++; if (ifa.stall_cnt !== 4'd14) begin miscompares++; $display("FAIL sat_stall_cnt_14: got %0d expected 14", ifa.stall_cnt); end
      end
      if (p == 20) begin
        vectors++; if (ifa.stall_D !== 1'b1) begin miscompares++; $display("FAIL sat_stall_D: got %b expected 1", ifa.stall_D); end
      end
    end
    @(posedge clk); #1; drive(nop());
    @(negedge clk);
    vectors++; if (ifa.stall_cnt !== 4'd15) begin miscompares++; $display("FAIL sat_stall_cnt: got %0d expected 15", ifa.stall_cnt); end
    br = nop();
    br.br = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1; drive(br);
    end
    @(posedge clk); #1; drive(nop());
    @(negedge clk);
    vectors++; if (ifa.flush_cnt !== 4'd15) begin miscompares++; $display("FAIL sat_flush_cnt_a: got %0d expected 15", ifa.flush_cnt); end
    vectors++; if (ifb.flush_cnt !== 16'd20) begin miscompares++; $display("FAIL sat_flush_cnt_b: got %0d expected 20", ifb.flush_cnt); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fwd_alu();
    test_load_use();
    test_zero_reg();
    test_wb_bypass();
    test_branch_flush();
    test_no_forward();
    test_reset_mid_stall();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
